// File: rtl/ex_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : ex_muldiv_unit
// Description : Iterative RV64 M-extension multiply/divide unit for the
//               execute stage. Radix-2 shift-add multiply and restoring
//               divide on operand magnitudes, one bit per cycle, with the
//               ID/EX stall and a single-cycle done/result pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_muldiv_unit #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            valid_in,
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic            flush,
    output logic            stall_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_MUL  = 2'd1;
    localparam logic [1:0] c_DIV  = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    localparam int                 c_CNT_W  = $clog2(XLEN) + 1;
    localparam logic [c_CNT_W-1:0] c_ITER_X = c_CNT_W'(XLEN);
    localparam logic [c_CNT_W-1:0] c_ITER_W = c_CNT_W'(32);
    localparam logic [c_CNT_W-1:0] c_ONE    = c_CNT_W'(1);
    localparam logic [XLEN-1:0]    c_MIN    = {1'b1, {(XLEN-1){1'b0}}};

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return {{(XLEN-32){v[31]}}, v};
    endfunction

    logic [1:0]          r_state;
    logic [c_CNT_W-1:0]  r_count;
    logic [2*XLEN-1:0]   r_mcand;
    logic [XLEN-1:0]     r_mplier;
    logic [2*XLEN-1:0]   r_acc;
    logic [XLEN-1:0]     r_quo;
    logic [XLEN-1:0]     r_rem;
    logic [XLEN-1:0]     r_dvsr;
    logic                r_neg_q;   // negate product / quotient
    logic                r_neg_r;   // negate remainder
    logic                r_w;       // 32-bit (W) operation
    logic                r_pick;    // mul: high half; div: remainder
    logic [XLEN-1:0]     r_result;

    // ---------------- operand decode at accept ----------------
    logic            w_is_div, w_is_w, w_a_sgn, w_b_sgn, w_a_neg, w_b_neg;
    logic [XLEN-1:0] w_a_ext, w_b_ext, w_a_mag, w_b_mag;
    logic            w_b_zero, w_ovf, w_special;
    logic [XLEN-1:0] w_dvd_res, w_special_res;

    assign w_is_div = op[2];
    assign w_is_w   = op[3];
    // MULW only needs the low product half, so its operands stay unsigned.
    assign w_a_sgn  = w_is_div ? !op[0] : (!w_is_w && (op[1:0] != 2'b11));
    assign w_b_sgn  = w_is_div ? !op[0] : (!w_is_w && !op[1]);
    assign w_a_ext  = w_is_w ? {{(XLEN-32){w_a_sgn & src_a[31]}}, src_a[31:0]} : src_a;
    assign w_b_ext  = w_is_w ? {{(XLEN-32){w_b_sgn & src_b[31]}}, src_b[31:0]} : src_b;
    assign w_a_neg  = w_a_sgn & w_a_ext[XLEN-1];
    assign w_b_neg  = w_b_sgn & w_b_ext[XLEN-1];
    assign w_a_mag  = w_a_neg ? -w_a_ext : w_a_ext;
    assign w_b_mag  = w_b_neg ? -w_b_ext : w_b_ext;

    assign w_b_zero = w_is_w ? (src_b[31:0] == 32'd0) : (src_b == '0);
    assign w_ovf    = !op[0] && (w_is_w ?
                      (src_a[31:0] == 32'h8000_0000 && src_b[31:0] == 32'hFFFF_FFFF) :
                      (src_a == c_MIN && src_b == '1));
    assign w_special = w_b_zero | w_ovf;
    assign w_dvd_res = w_is_w ? sext32(src_a[31:0]) : src_a;
    // Divide-by-zero wins the select; it cannot coexist with overflow.
    assign w_special_res = op[1] ? (w_b_zero ? w_dvd_res : '0)
                                 : (w_b_zero ? '1 : w_dvd_res);

    // ---------------- multiply step and final result ----------------
    logic [2*XLEN-1:0] w_acc_next, w_prod;
    logic [XLEN-1:0]   w_mul_res;

    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign w_prod     = r_neg_q ? -w_acc_next : w_acc_next;
    assign w_mul_res  = r_w    ? sext32(w_prod[31:0]) :
                        r_pick ? w_prod[2*XLEN-1:XLEN] : w_prod[XLEN-1:0];

    // ---------------- divide step and final result ----------------
    logic [XLEN:0]   w_rem_sh, w_diff;
    logic            w_ge;
    logic [XLEN-1:0] w_rem_next, w_quo_next, w_q_fix, w_r_fix, w_sel_div, w_div_res;

    assign w_rem_sh   = {r_rem, r_quo[XLEN-1]};
    assign w_diff     = w_rem_sh - {1'b0, r_dvsr};
    assign w_ge       = !w_diff[XLEN];
    assign w_rem_next = w_ge ? w_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0];
    assign w_quo_next = {r_quo[XLEN-2:0], w_ge};
    assign w_q_fix    = r_neg_q ? -w_quo_next : w_quo_next;
    assign w_r_fix    = r_neg_r ? -w_rem_next : w_rem_next;
    assign w_sel_div  = r_pick ? w_r_fix : w_q_fix;
    assign w_div_res  = r_w ? sext32(w_sel_div[31:0]) : w_sel_div;

    // ---------------- handshake outputs ----------------
    assign done_o   = (r_state == c_DONE);
    assign result_o = r_result;
    assign stall_o  = valid_in && !done_o && !flush;

    // Control FSM plus the iterative datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= c_IDLE;
            r_count  <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_quo    <= '0;
            r_rem    <= '0;
            r_dvsr   <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_w      <= 1'b0;
            r_pick   <= 1'b0;
            r_result <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (valid_in && !flush) begin
                        r_mcand  <= {{XLEN{1'b0}}, w_a_mag};
                        r_mplier <= w_b_mag;
                        r_acc    <= '0;
                        // W dividends are left-aligned so the MSB is always shifted out first.
                        r_quo    <= w_is_w ? (w_a_mag << (XLEN-32)) : w_a_mag;
                        r_rem    <= '0;
                        r_dvsr   <= w_b_mag;
                        r_neg_q  <= w_a_neg ^ w_b_neg;
                        r_neg_r  <= w_a_neg;
                        r_w      <= w_is_w;
                        r_pick   <= w_is_div ? op[1] : (op[1:0] != 2'b00);
                        r_count  <= w_is_w ? c_ITER_W : c_ITER_X;
                        if (!w_is_div) begin
                            r_state <= c_MUL;
                        end else if (w_special) begin
                            r_result <= w_special_res;
                            r_state  <= c_DONE;
                        end else begin
                            r_state <= c_DIV;
                        end
                    end
                end
                c_MUL: begin
                    if (flush) begin
                        r_state <= c_IDLE;
                    end else begin
                        r_acc    <= w_acc_next;
                        r_mcand  <= r_mcand << 1;
                        r_mplier <= r_mplier >> 1;
                        r_count  <= r_count - c_ONE;
                        if (r_count == c_ONE) begin
                            r_result <= w_mul_res;
                            r_state  <= c_DONE;
                        end
                    end
                end
                c_DIV: begin
                    if (flush) begin
                        r_state <= c_IDLE;
                    end else begin
                        r_rem   <= w_rem_next;
                        r_quo   <= w_quo_next;
                        r_count <= r_count - c_ONE;
                        if (r_count == c_ONE) begin
                            r_result <= w_div_res;
                            r_state  <= c_DONE;
                        end
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_muldiv_unit
// Description : Self-checking bench for ex_muldiv_unit: directed vector
//               table, randomized ops against an arithmetic reference model,
//               and hand-written flush / reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_in;
    logic [3:0]  op;
    logic [63:0] src_a, src_b;
    logic        flush;
    logic        stall_o, done_o;
    logic [63:0] result_o;

    int checks = 0;
    int errors = 0;

    ex_muldiv_unit #(.XLEN(64)) dut (
        .clk      (clk),
        .reset    (reset),
        .valid_in (valid_in),
        .op       (op),
        .src_a    (src_a),
        .src_b    (src_b),
        .flush    (flush),
        .stall_o  (stall_o),
        .done_o   (done_o),
        .result_o (result_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    localparam logic [63:0] c_ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] c_MIN  = 64'h8000_0000_0000_0000;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference result straight from the ISA arithmetic rules.
    function automatic logic [63:0] ref_res(input logic [3:0] o, input logic [63:0] a, input logic [63:0] b);
        logic [127:0]   ea, eb, p;
        longint         sa, sb;
        longint unsigned ua, ub;
        int             sa32, sb32;
        int unsigned    ua32, ub32;
        logic [31:0]    r32;
        logic [63:0]    r64;
        sa = a; sb = b; ua = a; ub = b;
        sa32 = a[31:0]; sb32 = b[31:0]; ua32 = a[31:0]; ub32 = b[31:0];
        if (!o[2]) begin
            if (o[3]) begin
                r32 = a[31:0] * b[31:0];
                return {{32{r32[31]}}, r32};
            end
            ea = (o[1:0] == 2'd3) ? {64'd0, a} : {{64{a[63]}}, a};
            eb = o[1] ? {64'd0, b} : {{64{b[63]}}, b};
            p  = ea * eb;
            return (o[1:0] == 2'd0) ? p[63:0] : p[127:64];
        end
        if (!o[3]) begin
            case (o[1:0])
                2'd0:    if (b == 0) r64 = c_ONES; else if (a == c_MIN && b == c_ONES) r64 = a; else r64 = sa / sb;
                2'd1:    if (b == 0) r64 = c_ONES; else r64 = ua / ub;
                2'd2:    if (b == 0) r64 = a; else if (a == c_MIN && b == c_ONES) r64 = 0; else r64 = sa % sb;
                default: if (b == 0) r64 = a; else r64 = ua % ub;
            endcase
            return r64;
        end
        case (o[1:0])
            2'd0:    if (ub32 == 0) r32 = 32'hFFFF_FFFF; else if (sa32 == 32'h8000_0000 && sb32 == -1) r32 = a[31:0]; else r32 = sa32 / sb32;
            2'd1:    if (ub32 == 0) r32 = 32'hFFFF_FFFF; else r32 = ua32 / ub32;
            2'd2:    if (ub32 == 0) r32 = a[31:0]; else if (sa32 == 32'h8000_0000 && sb32 == -1) r32 = 0; else r32 = sa32 % sb32;
            default: if (ub32 == 0) r32 = a[31:0]; else r32 = ua32 % ub32;
        endcase
        return {{32{r32[31]}}, r32};
    endfunction

    // Accept-to-done latency from the timing rules.
    function automatic int ref_lat(input logic [3:0] o, input logic [63:0] a, input logic [63:0] b);
        bit dz, ovf;
        if (!o[2]) return o[3] ? 33 : 65;
        dz  = o[3] ? (b[31:0] == 0) : (b == 0);
        ovf = !o[0] && (o[3] ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                             : (a == c_MIN && b == c_ONES));
        return (dz || ovf) ? 1 : (o[3] ? 33 : 65);
    endfunction

    function automatic logic [63:0] pick_val();
        case ($urandom_range(0, 7))
            0: return 64'd0;
            1: return 64'd1;
            2: return c_ONES;
            3: return c_MIN;
            4: return 64'hFFFF_FFFF_8000_0000;
            5: return 64'h0000_0000_FFFF_FFFF;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // Issue one op from IDLE, scramble inputs while busy, check done pulse.
    task automatic run_op(input string nm, input logic [3:0] o, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] exp, input int lat);
        int cyc;
        bit seen, stall_bad;
        op = o; src_a = a; src_b = b; valid_in = 1'b1; flush = 1'b0;
        #1;
        chk({nm, " stall_accept"}, 64'(stall_o), 64'd1);
        cyc = 0; seen = 0; stall_bad = 0;
        while (!seen && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
            if (done_o) seen = 1;
            else begin
                if (!stall_o) stall_bad = 1;
                op = 4'($urandom); src_a = {$urandom, $urandom}; src_b = {$urandom, $urandom};
            end
        end
        chk({nm, " done_seen"}, 64'(seen), 64'd1);
        if (seen) begin
            chk({nm, " latency"}, 64'(cyc), 64'(lat));
            chk({nm, " result"}, result_o, exp);
            chk({nm, " stall_done"}, 64'(stall_o), 64'd0);
        end
        chk({nm, " stall_busy"}, 64'(stall_bad), 64'd0);
        valid_in = 1'b0;
        @(posedge clk); #1;
        chk({nm, " single_pulse"}, 64'(done_o), 64'd0);
    endtask

    vec_t vecs[15];

    initial begin
        bit seen;
        logic [3:0]  ro;
        logic [63:0] ra, rb;

        vecs[0]  = '{4'd0,  64'd7,  64'd6,  64'd42, 65};
        vecs[1]  = '{4'd3,  c_ONES, c_ONES, 64'hFFFF_FFFF_FFFF_FFFE, 65};
        vecs[2]  = '{4'd1,  c_ONES, c_ONES, 64'd0, 65};
        vecs[3]  = '{4'd2,  c_ONES, 64'd2,  c_ONES, 65};
        vecs[4]  = '{4'd4,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65};
        vecs[5]  = '{4'd6,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2, c_ONES, 65};
        vecs[6]  = '{4'd5,  64'd100, 64'd7, 64'd14, 65};
        vecs[7]  = '{4'd7,  64'd100, 64'd7, 64'd2, 65};
        vecs[8]  = '{4'd5,  64'd5,  64'd0,  c_ONES, 1};
        vecs[9]  = '{4'd6,  64'd5,  64'd0,  64'd5, 1};
        vecs[10] = '{4'd4,  c_MIN,  c_ONES, c_MIN, 1};
        vecs[11] = '{4'd6,  c_MIN,  c_ONES, 64'd0, 1};
        vecs[12] = '{4'd12, 64'h0000_0000_8000_0000, c_ONES, 64'hFFFF_FFFF_8000_0000, 1};
        vecs[13] = '{4'd8,  64'h0000_0001_0000_0003, 64'd5, 64'd15, 33};
        vecs[14] = '{4'd13, 64'hFFFF_FFFF_0000_0064, 64'd7, 64'd14, 33};

        reset = 1'b1; valid_in = 1'b0; flush = 1'b0; op = '0; src_a = '0; src_b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset done_o", 64'(done_o), 64'd0);
        chk("reset result_o", result_o, 64'd0);
        chk("reset stall_o", 64'(stall_o), 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 15; i++)
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);

        for (int i = 0; i < 40; i++) begin
            ro = 4'($urandom); ra = pick_val(); rb = pick_val();
            run_op($sformatf("rand%0d op%0d", i, ro), ro, ra, rb, ref_res(ro, ra, rb), ref_lat(ro, ra, rb));
        end

        // Flush at cycle 20 of a DIV, then a MUL right after.
        op = 4'd4; src_a = 64'd1000; src_b = 64'd7; valid_in = 1'b1; seen = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done_o) seen = 1;
        end
        flush = 1'b1; #1;
        chk("flush stall_o", 64'(stall_o), 64'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        if (done_o) seen = 1;
        chk("flush no_done", 64'(seen), 64'd0);
        run_op("flush then mul", 4'd0, 64'd3, 64'd3, 64'd9, 65);

        // Flush has priority over accept in IDLE (a div-by-zero would pulse in one cycle).
        op = 4'd5; src_a = 64'd5; src_b = 64'd0; valid_in = 1'b1; flush = 1'b1; #1;
        chk("idle flush stall_o", 64'(stall_o), 64'd0);
        @(posedge clk); #1;
        valid_in = 1'b0; flush = 1'b0; seen = 0;
        if (done_o) seen = 1;
        repeat (3) begin
            @(posedge clk); #1;
            if (done_o) seen = 1;
        end
        chk("idle flush no_accept", 64'(seen), 64'd0);

        // Reset at cycle 10 of a MUL.
        op = 4'd0; src_a = 64'd5; src_b = 64'd5; valid_in = 1'b1; seen = 0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; valid_in = 1'b0;
        repeat (80) begin
            @(posedge clk); #1;
            if (done_o) seen = 1;
        end
        chk("reset midop no_done", 64'(seen), 64'd0);
        chk("reset midop result_o", result_o, 64'd0);
        run_op("after reset mul", 4'd0, 64'd3, 64'd4, 64'd12, 65);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Iterative RV64 M-extension multiply/divide unit in the execute stage.
- Consumes operands held in the ID/EX register.
- Drives the stall that freezes that register while an operation is in flight.
- Returns a single-cycle done/result pulse to the EX/MEM path.

Parameters:
- XLEN, 64, operand/result width; must be even.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- valid_in  input  1  ID/EX holds a muldiv instruction
- op  input  4  operation code (see Behaviour)
- src_a  input  XLEN  rs1 value
- src_b  input  XLEN  rs2 value
- flush  input  1  kill in-flight operation (branch mispredict/exception)
- stall_o  output  1  hold ID/EX and earlier stages
- done_o  output  1  one-cycle pulse, result_o valid
- result_o  output  XLEN  final result

Behaviour:
- Reset: state IDLE; done_o=0; result_o=0; all internal accumulators and counters 0. Reset mid-operation aborts the operation; no done_o follows.
- Op encoding:
  - 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU
  - 4 DIV, 5 DIVU, 6 REM, 7 REMU
  - 8 MULW
  - 12 DIVW, 13 DIVUW, 14 REMW, 15 REMUW
  - Codes 9-11 behave as MULW.
- States:
  - IDLE: accept when valid_in && !flush.
    - Mul op → MUL.
    - Div op with special case → DONE.
    - Otherwise → DIV.
  - MUL: radix-2 shift-add, one bit per cycle. N iterations (N=XLEN, or 32 for W ops), then → DONE.
  - DIV: restoring divide on magnitudes, one quotient bit per cycle. N iterations, then → DONE.
  - DONE: done_o=1 and result_o valid for exactly this cycle; → IDLE unconditionally. Never re-accepts the still-present valid_in in this cycle.
- Latency (accept edge to done_o cycle):
  - N+1 cycles for mul and normal div.
  - 1 cycle for div special cases.
  - Back-to-back ops: the next accept is the cycle after DONE.
- stall_o: combinational, equal to valid_in && !done_o && !flush. High in the accept cycle and every busy cycle; low in the DONE cycle so ID/EX advances on that edge.
- Signedness:
  - Signed ops take magnitudes at accept and record result signs.
  - Quotient sign = sign(a) XOR sign(b).
  - Remainder sign = sign(a).
  - MULHSU: a signed, b unsigned.
  - Full 2*XLEN product; MUL returns low half, MULH* return high half.
- W ops: operands truncated to low 32 bits (sign- or zero-extended per op), computed over 32 bits, result sign-extended from bit 31 to XLEN. MULW returns the sign-extended low 32 bits of the product.
- Divide by zero (divisor==0, evaluated on the relevant width):
  - quotient = all ones
  - remainder = dividend (W ops: sign-extended 32-bit dividend)
- Signed overflow (dividend = most-negative, divisor = -1, on relevant width):
  - quotient = dividend
  - remainder = 0
- flush: in any busy state, returns to IDLE on the next edge; no done_o pulse. Flush in the DONE cycle has no effect (the result already pulsed). Flush has priority over accept in IDLE.
- Operands are latched at accept. Later changes on src_a, src_b or op are ignored until IDLE.

Test Plan:
- MUL a=7, b=6 → stall_o high for 64 cycles after accept; done_o at cycle 65 with result_o=42; stall_o low in that cycle.
- MULHU a=b=0xFFFF_FFFF_FFFF_FFFF → result_o=0xFFFF_FFFF_FFFF_FFFE. MULH a=-1, b=-1 → 0. MULHSU a=-1, b=2 → 0xFFFF_FFFF_FFFF_FFFF.
- DIV a=-7, b=2 → -3; REM a=-7, b=2 → -1; DIVU a=100, b=7 → 14; REMU a=100, b=7 → 2; each done at cycle 65.
- Divide by zero and overflow:
  - DIVU a=5, b=0 → all ones at cycle 1.
  - REM a=5, b=0 → 5 at cycle 1.
  - DIV a=0x8000_0000_0000_0000, b=-1 → 0x8000_0000_0000_0000.
  - REM of the same operands → 0.
- W ops:
  - DIVW a=0x0000_0000_8000_0000, b=0xFFFF_FFFF_FFFF_FFFF → 0xFFFF_FFFF_8000_0000.
  - MULW a=0x1_0000_0003, b=5 → 15, done at cycle 33.
- Flush and reset mid-operation:
  - Assert flush at cycle 20 of a DIV → no done_o; IDLE next cycle; a new MUL 3*3 accepted on the following cycle returns 9.
  - Reset at cycle 10 of a MUL → done_o stays 0 and result_o=0.
